// File: rtl/scaler_pad_lines.sv
// Constant-value vertical padding generator: emits `lines` rows of `len` beats,
// each beat carrying the latched pad value replicated PIXEL_NUM times.
module scaler_pad_lines #(
    parameter int PIXEL_BITWIDTH = 8,
    parameter int PIXEL_NUM      = 2,
    parameter int IMG_H_MAX      = 3840,
    parameter int IMG_V_MAX      = 2160,
    parameter int IMG_H_BITWIDTH = $clog2(IMG_H_MAX),
    parameter int IMG_V_BITWIDTH = $clog2(IMG_V_MAX)
) (
    input  logic                                s_clk,
    input  logic                                s_rst,
    input  logic                                start,
    input  logic [IMG_H_BITWIDTH-1:0]           len,
    input  logic [IMG_V_BITWIDTH-1:0]           lines,
    input  logic [PIXEL_BITWIDTH-1:0]           pad_value,
    output logic                                busy,
    output logic                                done,
    output logic                                m_axis_valid,
    input  logic                                m_axis_ready,
    output logic                                m_axis_last,
    output logic                                m_axis_user,
    output logic [PIXEL_BITWIDTH*PIXEL_NUM-1:0] m_axis_pixel
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [IMG_H_BITWIDTH-1:0] H_ZERO = {IMG_H_BITWIDTH{1'b0}};
    localparam logic [IMG_H_BITWIDTH-1:0] H_ONE  = {{(IMG_H_BITWIDTH-1){1'b0}}, 1'b1};
    localparam logic [IMG_V_BITWIDTH-1:0] V_ZERO = {IMG_V_BITWIDTH{1'b0}};
    localparam logic [IMG_V_BITWIDTH-1:0] V_ONE  = {{(IMG_V_BITWIDTH-1){1'b0}}, 1'b1};

    state_t                      state_r, state_s;
    logic [IMG_H_BITWIDTH-1:0]   x_cnt_r, x_cnt_s;
    logic [IMG_V_BITWIDTH-1:0]   y_cnt_r, y_cnt_s;
    logic [IMG_H_BITWIDTH-1:0]   len_q_r, len_q_s;
    logic [IMG_V_BITWIDTH-1:0]   lines_q_r, lines_q_s;
    logic [PIXEL_BITWIDTH-1:0]   pad_q_r, pad_q_s;
    logic                        done_r, done_s;
    logic                        run_s;
    logic                        handshake_s;
    logic                        line_end_s;
    logic                        run_end_s;

    // The decrements below are only meaningful in RUN, where len_q/lines_q are nonzero.
    assign run_s       = (state_r == ST_RUN);
    assign handshake_s = run_s & m_axis_ready;
    assign line_end_s  = (x_cnt_r == (len_q_r - H_ONE));
    assign run_end_s   = line_end_s & (y_cnt_r == (lines_q_r - V_ONE));

    assign busy         = run_s;
    assign m_axis_valid = run_s;
    assign done         = done_r;
    assign m_axis_last  = run_s & line_end_s;
    assign m_axis_user  = run_s & (x_cnt_r == H_ZERO) & (y_cnt_r == V_ZERO);
    assign m_axis_pixel = {PIXEL_NUM{pad_q_r}};

    // Next-state, counter and config-latch logic.
    always_comb begin
        state_s   = state_r;
        x_cnt_s   = x_cnt_r;
        y_cnt_s   = y_cnt_r;
        len_q_s   = len_q_r;
        lines_q_s = lines_q_r;
        pad_q_s   = pad_q_r;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    len_q_s   = len;
                    lines_q_s = lines;
                    pad_q_s   = pad_value;
                    x_cnt_s   = H_ZERO;
                    y_cnt_s   = V_ZERO;
                    if ((len == H_ZERO) || (lines == V_ZERO)) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (handshake_s) begin
                    if (line_end_s) begin
                        x_cnt_s = H_ZERO;
                        if (run_end_s) begin
                            state_s = ST_IDLE;
                            done_s  = 1'b1;
                        end else begin
                            y_cnt_s = y_cnt_r + V_ONE;
                        end
                    end else begin
                        x_cnt_s = x_cnt_r + H_ONE;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and latched-config registers.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_r   <= ST_IDLE;
            x_cnt_r   <= H_ZERO;
            y_cnt_r   <= V_ZERO;
            len_q_r   <= H_ZERO;
            lines_q_r <= V_ZERO;
            pad_q_r   <= {PIXEL_BITWIDTH{1'b0}};
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            x_cnt_r   <= x_cnt_s;
            y_cnt_r   <= y_cnt_s;
            len_q_r   <= len_q_s;
            lines_q_r <= lines_q_s;
            pad_q_r   <= pad_q_s;
            done_r    <= done_s;
        end
    end

endmodule
